// File: rtl/booth4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth4_seq
//  Brief    : Sequential radix-4 Booth multiplier, one digit per clock,
//             start/busy/done handshake, signed two's-complement operands.
//  Revision : 1.0  initial release
// ============================================================================
module booth4_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int C_NDIG = WIDTH / 2;
   localparam int C_CW   = (C_NDIG > 1) ? $clog2(C_NDIG) : 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'(C_NDIG - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_m;     // sign-extended multiplicand, pre-shifted by 2i
   logic [WIDTH:0]       r_bx;    // multiplier with implicit b[-1]=0, shifted by 2i
   logic [2*WIDTH-1:0]   r_acc;
   logic [C_CW-1:0]      r_idx;
   logic [2*WIDTH-1:0]   w_pp;
   logic [2*WIDTH-1:0]   w_sum;
   logic                 w_accept;

   assign w_accept = start && (r_state != S_CALC);

   always_comb begin
      w_pp = '0;
      case (r_bx[2:0])
         3'b001, 3'b010: w_pp = r_m;
         3'b011:         w_pp = r_m << 1;
         3'b100:         w_pp = -(r_m << 1);
         3'b101, 3'b110: w_pp = -r_m;
         default:        w_pp = '0;
      endcase
   end

   assign w_sum = r_acc + w_pp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_bx    <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         prod    <= '0;
      end else if (w_accept) begin
         r_m     <= {{WIDTH{a[WIDTH-1]}}, a};
         r_bx    <= {b, 1'b0};
         r_acc   <= '0;
         r_idx   <= '0;
         r_state <= S_CALC;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (r_state)
            S_CALC: begin
               r_acc <= w_sum;
               r_m   <= r_m << 2;
               r_bx  <= r_bx >> 2;
               r_idx <= r_idx + 1'b1;
               if (r_idx == C_LAST) begin
                  prod    <= w_sum;
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               done    <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
